// File: rtl/digit_scan_driver.sv
// digit_scan_driver
// Self-running, time-multiplexed digit scanner for a multi-digit 7-segment
// display. Each digit is held for CLK_DIV cycles. The first BLANK_CYC cycles
// of each hold are a guard interval with every position off, which prevents
// ghosting. Digits can be blanked, or blinked every BLINK_FRAMES full frames.
//
// Ports:
//   clk, rst    system clock; asynchronous active-high reset
//   en          scan enable (0 = freeze scan state, positions off)
//   digit_data  packed BCD, digit i = bits [4i+3:4i]
//   blank_mask  1 = digit never lit
//   blink_mask  1 = digit dark during the blink-off phase
//   pos         one-hot digit select (inverted when ACTIVE_LOW)
//   bcd_out     BCD code of the current digit
//   cur_idx     current digit index
//   frame_tick  one-cycle pulse after the index wraps to 0
module digit_scan_driver #(
  parameter  int DIGITS       = 6,
  parameter  int SEL_W        = 8,
  parameter  int CLK_DIV      = 50000,
  parameter  int BLANK_CYC    = 16,
  parameter  int BLINK_FRAMES = 64,
  parameter  int ACTIVE_LOW   = 0,
  localparam int IDX_W        = (DIGITS > 1) ? $clog2(DIGITS) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [4*DIGITS-1:0]   digit_data,
  input  logic [DIGITS-1:0]     blank_mask,
  input  logic [DIGITS-1:0]     blink_mask,
  output logic [SEL_W-1:0]      pos,
  output logic [3:0]            bcd_out,
  output logic [IDX_W-1:0]      cur_idx,
  output logic                  frame_tick
);

  localparam int CNT_W = $clog2(CLK_DIV);
  localparam int FRM_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);
  localparam logic [FRM_W-1:0] FRM_LAST = FRM_W'(BLINK_FRAMES - 1);
  localparam logic [SEL_W-1:0] POS_IDLE = (ACTIVE_LOW != 0) ? {SEL_W{1'b1}} : {SEL_W{1'b0}};

  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [IDX_W-1:0] idx_nxt;
  logic [FRM_W-1:0] frm, frm_nxt;
  logic             ph, ph_nxt;
  logic             wrap;
  logic             guard;
  logic             blank_sel, blink_sel, lit;
  logic [3:0]       bcd_nxt;
  logic [SEL_W-1:0] pos_raw, pos_nxt;

  // Next-state of the scan counters; everything holds while en=0.
  always_comb begin
    cnt_nxt = cnt;
    idx_nxt = cur_idx;
    frm_nxt = frm;
    ph_nxt  = ph;
    wrap    = 1'b0;
    if (en) begin
      if (cnt == CNT_LAST) begin
        cnt_nxt = '0;
        if (cur_idx == IDX_LAST) begin
          idx_nxt = '0;
          wrap    = 1'b1;
        end else begin
          idx_nxt = cur_idx + 1'b1;
        end
      end else begin
        cnt_nxt = cnt + 1'b1;
      end
      if (wrap) begin
        if (frm == FRM_LAST) begin
          frm_nxt = '0;
          ph_nxt  = ~ph;
        end else begin
          frm_nxt = frm + 1'b1;
        end
      end
    end
  end

  // Guard interval is judged on the next prescaler value so pos lines up
  // with the prescaler state it is registered alongside.
  generate
    if (BLANK_CYC == 0) begin : g_no_guard
      assign guard = 1'b0;
    end else begin : g_guard
      localparam logic [CNT_W-1:0] BLANK_V = CNT_W'(BLANK_CYC);
      assign guard = (cnt_nxt < BLANK_V);
    end
  endgenerate

  // Output selection uses next-state index so pos, bcd_out and cur_idx
  // always change together.
  always_comb begin
    bcd_nxt   = '0;
    blank_sel = 1'b0;
    blink_sel = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx_nxt == IDX_W'(i)) begin
        bcd_nxt   = digit_data[4*i +: 4];
        blank_sel = blank_mask[i];
        blink_sel = blink_mask[i];
      end
    end
    lit     = en && !guard && !blank_sel && !(ph_nxt && blink_sel);
    pos_raw = lit ? (SEL_W'(1) << idx_nxt) : '0;
    pos_nxt = (ACTIVE_LOW != 0) ? ~pos_raw : pos_raw;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt        <= '0;
      cur_idx    <= '0;
      frm        <= '0;
      ph         <= 1'b0;
      frame_tick <= 1'b0;
      bcd_out    <= '0;
      pos        <= POS_IDLE;
    end else begin
      cnt        <= cnt_nxt;
      cur_idx    <= idx_nxt;
      frm        <= frm_nxt;
      ph         <= ph_nxt;
      frame_tick <= wrap;
      bcd_out    <= bcd_nxt;
      pos        <= pos_nxt;
    end
  end

endmodule

// File: tb/tb_digit_scan_driver.sv
// Directed bench for digit_scan_driver. Instance a uses the main test
// parameters; instance b is identical but active-low with no guard interval.
// Both instances share the same stimulus.
module tb_digit_scan_driver;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en  = 1'b0;
  logic [23:0] digit_data = 24'h543210;
  logic [5:0]  blank_mask = '0;
  logic [5:0]  blink_mask = '0;

  logic [7:0]  pos_a, pos_b;
  logic [3:0]  bcd_a, bcd_b;
  logic [2:0]  idx_a, idx_b;
  logic        ft_a, ft_b;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  digit_scan_driver #(.DIGITS(6), .SEL_W(8), .CLK_DIV(4), .BLANK_CYC(1),
                      .BLINK_FRAMES(2), .ACTIVE_LOW(0)) dut_a (
    .clk(clk), .rst(rst), .en(en), .digit_data(digit_data),
    .blank_mask(blank_mask), .blink_mask(blink_mask),
    .pos(pos_a), .bcd_out(bcd_a), .cur_idx(idx_a), .frame_tick(ft_a));

  digit_scan_driver #(.DIGITS(6), .SEL_W(8), .CLK_DIV(4), .BLANK_CYC(0),
                      .BLINK_FRAMES(2), .ACTIVE_LOW(1)) dut_b (
    .clk(clk), .rst(rst), .en(en), .digit_data(digit_data),
    .blank_mask(blank_mask), .blink_mask(blink_mask),
    .pos(pos_b), .bcd_out(bcd_b), .cur_idx(idx_b), .frame_tick(ft_b));

  // Apply reset across a couple of edges and release it at a falling edge;
  // the sample taken right after release is cycle k=0.
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(negedge clk);
    n_checks++;
    if (pos_a !== 8'h00) begin n_fail++; $display("FAIL reset_pos_a got %h exp 00", pos_a); end
    n_checks++;
    if (pos_b !== 8'hFF) begin n_fail++; $display("FAIL reset_pos_b got %h exp ff", pos_b); end
    n_checks++;
    if (idx_a !== 3'd0) begin n_fail++; $display("FAIL reset_idx got %0d exp 0", idx_a); end
    n_checks++;
    if (bcd_a !== 4'd0) begin n_fail++; $display("FAIL reset_bcd got %h exp 0", bcd_a); end
    n_checks++;
    if (ft_a !== 1'b0) begin n_fail++; $display("FAIL reset_ft got %b exp 0", ft_a); end
  endtask

  task automatic test_scan();
    logic [7:0] e_pos;
    int idx, cnt;
    blank_mask = '0; blink_mask = '0; digit_data = 24'h543210; en = 1'b1;
    do_reset();
    for (int k = 0; k < 48; k++) begin
      if (k > 0) @(negedge clk);
      idx = (k / 4) % 6;
      cnt = k % 4;
      e_pos = (cnt >= 1) ? (8'h01 << idx) : 8'h00;
      n_checks++;
      if (pos_a !== e_pos) begin n_fail++; $display("FAIL scan_pos k=%0d got %h exp %h", k, pos_a, e_pos); end
      n_checks++;
      if (idx_a !== 3'(idx)) begin n_fail++; $display("FAIL scan_idx k=%0d got %0d exp %0d", k, idx_a, idx); end
      n_checks++;
      if (bcd_a !== 4'(idx)) begin n_fail++; $display("FAIL scan_bcd k=%0d got %h exp %0d", k, bcd_a, idx); end
      n_checks++;
      if (ft_a !== ((k == 24) ? 1'b1 : 1'b0)) begin n_fail++; $display("FAIL scan_ft k=%0d got %b", k, ft_a); end
    end
  endtask

  task automatic test_blink();
    logic [7:0] e_pos;
    int idx, cnt, frame;
    logic dark;
    blank_mask = '0; blink_mask = 6'h01; digit_data = 24'h543210; en = 1'b1;
    do_reset();
    for (int k = 0; k < 104; k++) begin
      if (k > 0) @(negedge clk);
      idx   = (k / 4) % 6;
      cnt   = k % 4;
      frame = k / 24;
      dark  = (frame == 2) || (frame == 3);
      e_pos = (cnt >= 1 && !(idx == 0 && dark)) ? (8'h01 << idx) : 8'h00;
      n_checks++;
      if (pos_a !== e_pos) begin n_fail++; $display("FAIL blink_pos k=%0d got %h exp %h", k, pos_a, e_pos); end
    end
  endtask

  task automatic test_blank_invalid();
    logic [7:0] e_pos;
    logic [3:0] e_bcd;
    int idx, cnt;
    blank_mask = 6'h04; blink_mask = '0; digit_data = 24'h54C210; en = 1'b1;
    do_reset();
    for (int k = 0; k < 24; k++) begin
      if (k > 0) @(negedge clk);
      idx   = (k / 4) % 6;
      cnt   = k % 4;
      e_pos = (cnt >= 1 && idx != 2) ? (8'h01 << idx) : 8'h00;
      e_bcd = (idx == 3) ? 4'hC : 4'(idx);
      n_checks++;
      if (pos_a !== e_pos) begin n_fail++; $display("FAIL blank_pos k=%0d got %h exp %h", k, pos_a, e_pos); end
      n_checks++;
      if (bcd_a !== e_bcd) begin n_fail++; $display("FAIL blank_bcd k=%0d got %h exp %h", k, bcd_a, e_bcd); end
    end
  endtask

  task automatic test_enable_hold();
    blank_mask = '0; blink_mask = '0; digit_data = 24'h543210; en = 1'b1;
    do_reset();
    repeat (10) @(negedge clk);
    n_checks++;
    if (pos_a !== 8'h04 || idx_a !== 3'd2) begin
      n_fail++; $display("FAIL hold_setup got pos %h idx %0d exp 04 2", pos_a, idx_a);
    end
    en = 1'b0;
    for (int j = 0; j < 10; j++) begin
      @(negedge clk);
      n_checks++;
      if (pos_a !== 8'h00 || idx_a !== 3'd2 || bcd_a !== 4'd2) begin
        n_fail++; $display("FAIL hold_frozen j=%0d got pos %h idx %0d bcd %h exp 00 2 2", j, pos_a, idx_a, bcd_a);
      end
    end
    en = 1'b1;
    @(negedge clk);
    n_checks++;
    if (pos_a !== 8'h04 || idx_a !== 3'd2) begin n_fail++; $display("FAIL resume_1 got pos %h idx %0d exp 04 2", pos_a, idx_a); end
    @(negedge clk);
    n_checks++;
    if (pos_a !== 8'h00 || idx_a !== 3'd3) begin n_fail++; $display("FAIL resume_2 got pos %h idx %0d exp 00 3", pos_a, idx_a); end
    @(negedge clk);
    n_checks++;
    if (pos_a !== 8'h08 || idx_a !== 3'd3) begin n_fail++; $display("FAIL resume_3 got pos %h idx %0d exp 08 3", pos_a, idx_a); end
  endtask

  task automatic test_async_reset();
    blank_mask = '0; blink_mask = '0; digit_data = 24'h543210; en = 1'b1;
    do_reset();
    repeat (17) @(negedge clk);
    n_checks++;
    if (pos_a !== 8'h10 || idx_a !== 3'd4) begin n_fail++; $display("FAIL areset_setup got pos %h idx %0d exp 10 4", pos_a, idx_a); end
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if (pos_a !== 8'h00 || idx_a !== 3'd0 || bcd_a !== 4'd0) begin
      n_fail++; $display("FAIL areset_immediate got pos %h idx %0d bcd %h exp 00 0 0", pos_a, idx_a, bcd_a);
    end
    n_checks++;
    if (pos_b !== 8'hFF) begin n_fail++; $display("FAIL areset_pos_b got %h exp ff", pos_b); end
    @(negedge clk);
    rst = 1'b0;
    for (int k = 1; k <= 25; k++) begin
      @(negedge clk);
      n_checks++;
      if (ft_a !== ((k == 24) ? 1'b1 : 1'b0)) begin n_fail++; $display("FAIL areset_ft k=%0d got %b", k, ft_a); end
    end
  endtask

  task automatic test_polarity();
    logic [7:0] e_pos;
    int idx;
    blank_mask = '0; blink_mask = '0; digit_data = 24'h543210; en = 1'b1;
    do_reset();
    for (int k = 1; k < 25; k++) begin
      @(negedge clk);
      idx   = (k / 4) % 6;
      e_pos = ~(8'h01 << idx);
      n_checks++;
      if (pos_b !== e_pos) begin n_fail++; $display("FAIL polarity_pos k=%0d got %h exp %h", k, pos_b, e_pos); end
      n_checks++;
      if (idx_b !== 3'(idx)) begin n_fail++; $display("FAIL polarity_idx k=%0d got %0d exp %0d", k, idx_b, idx); end
    end
  endtask

  initial begin
    test_reset();
    test_scan();
    test_blink();
    test_blank_invalid();
    test_enable_hold();
    test_async_reset();
    test_polarity();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
